// File: rtl/cevero_soc.sv
// Fault-tolerant SoC top: two lockstep micro-sequencers sum 1..N. A checker
// compares them every cycle. Core 0 stores the result and a done flag in a small RAM.
module cevero_soc #(
   parameter logic [31:0] BOOT_ADDR  = 32'h0000_0080,
   parameter int          N          = 10,
   parameter int          RAM_WORDS  = 16,
   parameter int          RESULT_IDX = 1,
   parameter int          FLAG_IDX   = 0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        fetch_enable_i,
   output logic        signal,
   output logic [31:0] mem_flag,
   output logic [31:0] mem_result,
   output logic [31:0] instr_addr_0
);
   localparam int            AW     = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam logic [AW-1:0] RES_A  = AW'(RESULT_IDX);
   localparam logic [AW-1:0] FLAG_A = AW'(FLAG_IDX);
   localparam logic [31:0]   N_W    = 32'(N);

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_STORE_RES  = 2'd1,
      ST_STORE_FLAG = 2'd2,
      ST_DONE       = 2'd3
   } state_t;

   typedef struct packed {
      state_t      st;
      logic [31:0] pc;
      logic [31:0] acc;
      logic [31:0] i;
   } core_t;

   // One enabled step of the workload program; both cores share this definition.
   function automatic core_t core_step(input core_t c);
      core_t n;
      n = c;
      case (c.st)
         ST_RUN: begin
            n.acc = c.acc + c.i;
            n.i   = c.i + 32'd1;
            n.pc  = c.pc + 32'd4;
            if (c.i == N_W) n.st = ST_STORE_RES;
            else            n.st = ST_RUN;
         end
         ST_STORE_RES: begin
            n.pc = c.pc + 32'd4;
            n.st = ST_STORE_FLAG;
         end
         ST_STORE_FLAG: begin
            n.pc = c.pc + 32'd4;
            n.st = ST_DONE;
         end
         ST_DONE: n = c;
         default: n = c;
      endcase
      return n;
   endfunction

   state_t      r_st0, r_st1;
   logic [31:0] r_pc0, r_acc0, r_i0;
   logic [31:0] r_pc1, r_acc1, r_i1;
   logic        r_signal;
   logic [31:0] r_ram [RAM_WORDS];

   core_t         w_cur0, w_cur1, w_nxt0, w_nxt1;
   logic          w_mismatch, w_we;
   logic [AW-1:0] w_waddr;
   logic [31:0]   w_wdata;

   // Next-state of both cores, lockstep compare and core-0 write intent.
   always_comb begin
      w_cur0     = '{st: r_st0, pc: r_pc0, acc: r_acc0, i: r_i0};
      w_cur1     = '{st: r_st1, pc: r_pc1, acc: r_acc1, i: r_i1};
      w_mismatch = (w_cur0 != w_cur1);
      w_we       = 1'b0;
      w_waddr    = RES_A;
      w_wdata    = r_acc0;
      if (fetch_enable_i) begin
         w_nxt0 = core_step(w_cur0);
         w_nxt1 = core_step(w_cur1);
         case (r_st0)
            ST_STORE_RES: begin
               w_we    = 1'b1;
               w_waddr = RES_A;
               w_wdata = r_acc0;
            end
            ST_STORE_FLAG: begin
               w_we    = 1'b1;
               w_waddr = FLAG_A;
               w_wdata = 32'h0000_0001;
            end
            default: begin
               w_we    = 1'b0;
               w_waddr = RES_A;
               w_wdata = r_acc0;
            end
         endcase
      end else begin
         w_nxt0 = w_cur0;
         w_nxt1 = w_cur1;
      end
   end

   // Core registers, sticky mismatch flag and RAM; a mismatch resyncs core 1 to core 0.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_st0    <= ST_RUN;
         r_pc0    <= BOOT_ADDR;
         r_acc0   <= 32'd0;
         r_i0     <= 32'd1;
         r_st1    <= ST_RUN;
         r_pc1    <= BOOT_ADDR;
         r_acc1   <= 32'd0;
         r_i1     <= 32'd1;
         r_signal <= 1'b0;
         r_ram    <= '{default: 32'h0};
      end else begin
         r_st0  <= w_nxt0.st;
         r_pc0  <= w_nxt0.pc;
         r_acc0 <= w_nxt0.acc;
         r_i0   <= w_nxt0.i;
         if (w_mismatch) begin
            r_st1    <= w_nxt0.st;
            r_pc1    <= w_nxt0.pc;
            r_acc1   <= w_nxt0.acc;
            r_i1     <= w_nxt0.i;
            r_signal <= 1'b1;
         end else begin
            r_st1    <= w_nxt1.st;
            r_pc1    <= w_nxt1.pc;
            r_acc1   <= w_nxt1.acc;
            r_i1     <= w_nxt1.i;
            r_signal <= r_signal;
         end
         if (w_we) r_ram[w_waddr] <= w_wdata;
      end
   end

   assign signal       = r_signal;
   assign mem_flag     = r_ram[FLAG_A];
   assign mem_result   = r_ram[RESULT_IDX[AW-1:0]];
   assign instr_addr_0 = r_pc0;

endmodule

// File: tb/tb_cevero_soc.sv
// Self-checking bench for cevero_soc: a vector table, hand-written corner sequences
// and random rst/enable traffic checked against an edge-count model (N=10 and N=1).
module tb_cevero_soc;
   logic        clk_i = 1'b0;
   logic        rst_i, fetch_enable_i;
   logic        sig_a, sig_b;
   logic [31:0] flag_a, res_a, pc_a, flag_b, res_b, pc_b;

   int   checks   = 0;
   int   failures = 0;
   int   k        = 0;
   logic exp_sig  = 1'b0;

   cevero_soc #(.N(10)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .fetch_enable_i(fetch_enable_i),
      .signal(sig_a), .mem_flag(flag_a), .mem_result(res_a), .instr_addr_0(pc_a)
   );

   cevero_soc #(.N(1)) dut1 (
      .clk_i(clk_i), .rst_i(rst_i), .fetch_enable_i(fetch_enable_i),
      .signal(sig_b), .mem_flag(flag_b), .mem_result(res_b), .instr_addr_0(pc_b)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        rst;
      logic        en;
      logic [31:0] pc;
      logic [31:0] res;
      logic [31:0] flag;
   } vec_t;

   vec_t tv [15];

   // Model: outputs depend only on the number of enabled edges since reset.
   function automatic logic [31:0] m_pc(input int n, input int kk);
      int s;
      s = (kk < n + 2) ? kk : n + 2;
      return 32'h0000_0080 + 32'(4 * s);
   endfunction

   function automatic logic [31:0] m_res(input int n, input int kk);
      return (kk >= n + 1) ? 32'(n * (n + 1) / 2) : 32'd0;
   endfunction

   function automatic logic [31:0] m_flag(input int n, input int kk);
      return (kk >= n + 2) ? 32'd1 : 32'd0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (k=%0d t=%0t)", name, act, exp, k, $time);
      end
   endtask

   task automatic step(input logic r, input logic e);
      rst_i          = r;
      fetch_enable_i = e;
      @(posedge clk_i);
      if (r) begin
         k       = 0;
         exp_sig = 1'b0;
      end else if (e) begin
         k++;
      end
      @(negedge clk_i);
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".pc10"},   pc_a,   m_pc(10, k));
      chk({tag, ".res10"},  res_a,  m_res(10, k));
      chk({tag, ".flag10"}, flag_a, m_flag(10, k));
      chk({tag, ".sig10"},  32'(sig_a), 32'(exp_sig));
      chk({tag, ".pc1"},    pc_b,   m_pc(1, k));
      chk({tag, ".res1"},   res_b,  m_res(1, k));
      chk({tag, ".flag1"},  flag_b, m_flag(1, k));
      chk({tag, ".sig1"},   32'(sig_b), 32'd0);
   endtask

   initial begin
      logic [31:0] tmp;
      int          edges;
      bit          seen;

      rst_i          = 1'b1;
      fetch_enable_i = 1'b0;

      tv[0]  = '{1'b1, 1'b0, 32'h80, 32'd0,  32'd0};
      tv[1]  = '{1'b1, 1'b0, 32'h80, 32'd0,  32'd0};
      for (int e = 1; e <= 10; e++)
         tv[1 + e] = '{1'b0, 1'b1, 32'h80 + 32'(4 * e), 32'd0, 32'd0};
      tv[12] = '{1'b0, 1'b1, 32'hAC, 32'd55, 32'd0};
      tv[13] = '{1'b0, 1'b1, 32'hB0, 32'd55, 32'd1};
      tv[14] = '{1'b0, 1'b1, 32'hB0, 32'd55, 32'd1};

      // Baseline run from the table
      for (int v = 0; v < 15; v++) begin
         step(tv[v].rst, tv[v].en);
         chk("tbl.pc",   pc_a,   tv[v].pc);
         chk("tbl.res",  res_a,  tv[v].res);
         chk("tbl.flag", flag_a, tv[v].flag);
         chk("tbl.sig",  32'(sig_a), 32'd0);
         chk("tbl.pc1",  pc_b,   m_pc(1, k));
         chk("tbl.res1", res_b,  m_res(1, k));
         chk("tbl.flg1", flag_b, m_flag(1, k));
      end

      // Reset after completion, then an identical rerun
      step(1'b1, 1'b0);
      chk("rst.flag", flag_a, 32'd0);
      chk("rst.res",  res_a,  32'd0);
      chk("rst.pc",   pc_a,   32'h80);
      for (int e = 0; e < 14; e++) begin
         step(1'b0, 1'b1);
         check_all("rerun");
      end

      // Pause of 5 cycles after edge 4
      step(1'b1, 1'b0);
      for (int e = 0; e < 4; e++) step(1'b0, 1'b1);
      chk("pause.pc4", pc_a, 32'h90);
      for (int e = 0; e < 5; e++) begin
         step(1'b0, 1'b0);
         chk("pause.hold", pc_a, 32'h90);
         check_all("pause");
      end
      edges = 9;
      seen  = 1'b0;
      while (!seen && edges < 40) begin
         step(1'b0, 1'b1);
         edges++;
         check_all("resume");
         if (flag_a == 32'd1) seen = 1'b1;
      end
      chk("pause.flag_edge", 32'(edges), 32'd17);
      chk("pause.res", res_a, 32'd55);

      // Corrupt core 1 accumulator just before edge 5
      step(1'b1, 1'b0);
      for (int e = 0; e < 4; e++) step(1'b0, 1'b1);
      tmp = dut.r_acc1 + 32'd7;
      force dut.r_acc1 = tmp;
      #1;
      release dut.r_acc1;
      chk("fault.pre_sig", 32'(sig_a), 32'd0);
      step(1'b0, 1'b1);
      exp_sig = 1'b1;
      check_all("fault.e5");
      for (int e = 0; e < 9; e++) begin
         step(1'b0, 1'b1);
         check_all("fault.run");
      end
      chk("fault.res",  res_a,  32'd55);
      chk("fault.flag", flag_a, 32'd1);
      chk("fault.sig",  32'(sig_a), 32'd1);

      // Reset and enable together, mid-run
      for (int e = 0; e < 3; e++) begin
         step(1'b1, 1'b1);
         check_all("rsten");
      end

      // Random reset/enable traffic
      for (int c = 0; c < 400; c++) begin
         step(($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
         check_all("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cevero_soc.md
Name: cevero_soc

Overview:
Minimal fault-tolerant SoC top level, synthesizable.
- Two identical lockstep micro-sequencer cores run a fixed built-in workload: sum of 1..N.
- A checker compares the two cores every cycle.
- A small single-port data RAM receives the result and a completion flag.
- RAM result/flag words, the core-0 fetch address and the fault-detected indication are exported for bench observation.

Parameters:
BOOT_ADDR, 32'h0000_0080, fetch address of core after reset
N, 10, workload length; result = sum of 1..N; legal range 1..65535
RAM_WORDS, 16, data RAM depth in 32-bit words
RESULT_IDX, 1, RAM word index of result
FLAG_IDX, 0, RAM word index of completion flag

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous active-high reset
fetch_enable_i  in  1  core advance enable; 0 freezes both cores
signal  out  1  sticky lockstep-mismatch indicator
mem_flag  out  32  RAM[FLAG_IDX], combinational read
mem_result  out  32  RAM[RESULT_IDX], combinational read
instr_addr_0  out  32  core 0 program counter

Behaviour:
- Clock and reset: one clock clk_i. Reset rst_i is synchronous and active-high.
- Reset (sampled at a rising edge with rst_i=1):
  - Both cores: state=RUN, pc=BOOT_ADDR, acc=0, i=1.
  - All RAM words = 0.
  - signal=0.
  - Outputs after reset: mem_flag=0, mem_result=0, instr_addr_0=BOOT_ADDR, signal=0.
- Core FSM (per core). Updates only on an edge with rst_i=0 and fetch_enable_i=1; otherwise all core registers hold.
  - RUN: acc<=acc+i (32-bit, wraps mod 2^32), i<=i+1, pc<=pc+4. If i==N, next state STORE_RES.
  - STORE_RES: write RAM[RESULT_IDX]<=acc, pc<=pc+4, next STORE_FLAG.
  - STORE_FLAG: write RAM[FLAG_IDX]<=32'h1, pc<=pc+4, next DONE.
  - DONE: terminal; pc holds; no writes until reset.
- Latency from reset release with fetch_enable_i=1 continuously:
  - mem_result=sum(1..N) after enabled edge N+1.
  - mem_flag=1 after edge N+2.
  - Final instr_addr_0=BOOT_ADDR+4*(N+2).
  - Default N: result 55 at edge 11, flag at edge 12, final pc 32'hB0.
- RAM:
  - Single write port, driven only by core 0.
  - Core 1 write intents are compared, never applied.
  - At most one write per cycle; no read port contention, since outputs are combinational taps.
- Lockstep checker:
  - Each cycle, compare the state, pc, acc and i of core 0 and core 1.
  - Any difference: signal<=1 (sticky until reset), and on the same edge core 1 registers are reloaded from core 0's next values (resynchronisation).
  - Core 0's progress is never altered by a mismatch.
- fetch_enable_i low mid-run: full freeze, no RAM writes; resumes exactly where stopped.
- Reset mid-operation: returns everything to reset values on that edge, including clearing a set mem_flag/mem_result and signal.
- Simultaneous rst_i=1 and fetch_enable_i=1: reset wins.
- N=1: one RUN cycle, result 1 at edge 2, flag at edge 3.

Test Plan:
- Reset 2 cycles, then fetch_enable_i=1: instr_addr_0 steps 0x80,0x84,...; mem_result=55 after edge 11; mem_flag=1 after edge 12; instr_addr_0 stays 0xB0; signal=0 throughout.
- Drop fetch_enable_i for 5 cycles after edge 4, then raise it: instr_addr_0 holds 0x90 during the pause; mem_flag rises 5 cycles later than the baseline (edge 17); mem_result=55.
- After completion, assert rst_i 1 cycle: mem_flag=0, mem_result=0, instr_addr_0=0x80 next cycle; rerun completes identically.
- Force core 1 acc += 7 for one cycle at edge 5: signal=1 on the next edge and stays 1; mem_result still 55; mem_flag=1 at edge 12.
- Keep rst_i and fetch_enable_i both high for 3 cycles: outputs remain at reset values; no RAM writes.
- Parameter N=1: mem_result=1 at edge 2, mem_flag=1 at edge 3, final pc 0x8C.
